// File: rtl/pe_sched_ctrl.sv
// pe_sched_ctrl: row-pass sequencer for one PE; PE_SCHED_PERF_EN adds busy/stall perf counters
module pe_sched_ctrl #(
  parameter int CONFIG_BIT    = 5,
  parameter int PIPE_DEPTH    = 2,
  parameter int WIN_CNT_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     start,
  input  logic [CONFIG_BIT-1:0]    filter_size,
  input  logic [CONFIG_BIT-1:0]    ifmap_size,
  input  logic                     filter_ready,
  input  logic                     ifmap_valid,
  input  logic                     offset_co,
  input  logic                     psum_full,
  output logic                     pipe_en,
  output logic                     if_clear,
  output logic                     acc_clear,
  output logic                     psum_wr,
  output logic                     ifmap_pop,
  output logic                     busy,
  output logic                     done,
  output logic                     cfg_err,
`ifdef PE_SCHED_PERF_EN
  output logic [15:0]              perf_busy_cycles,
  output logic [15:0]              perf_stall_cycles,
`endif
  output logic [WIN_CNT_WIDTH-1:0] win_idx
);
  localparam int LW = WIN_CNT_WIDTH > CONFIG_BIT + 1 ? WIN_CNT_WIDTH : CONFIG_BIT + 1;
  typedef enum logic [2:0] {IDLE, LOAD_WAIT, COMPUTE, DRAIN, WRITE, FINISH} state_t;
  state_t state_q, state_d;
  logic [CONFIG_BIT-1:0] filt_q, filt_d, ifm_q, ifm_d;
  logic [WIN_CNT_WIDTH-1:0] win_q, win_d;
  logic [2:0] cnt_q, cnt_d;
  logic first_q, first_d;
  logic cfg_ok, last_win, ready;
  assign cfg_ok   = filter_size != '0 && ifmap_size >= filter_size;
  assign last_win = LW'(win_q) == LW'(ifm_q) - LW'(filt_q);
  assign ready    = filter_ready && ifmap_valid;
  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q <= IDLE;
      filt_q  <= '0;
      ifm_q   <= '0;
      win_q   <= '0;
      cnt_q   <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      filt_q  <= filt_d;
      ifm_q   <= ifm_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
    end
  end
  // next state; first_d flags the tap-0 cycle of every window
  always_comb begin
    state_d = state_q;
    filt_d  = filt_q;
    ifm_d   = ifm_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    first_d = 1'b0;
    case (state_q)
      IDLE: if (start && cfg_ok) begin
        state_d = LOAD_WAIT;
        filt_d  = filter_size;
        ifm_d   = ifmap_size;
      end
      LOAD_WAIT: if (ready) begin
        state_d = COMPUTE;
        win_d   = '0;
        first_d = 1'b1;
      end
      COMPUTE: if (offset_co) begin
        state_d = DRAIN;
        cnt_d   = '0;
      end
      DRAIN: begin
        cnt_d   = cnt_q + 3'd1;
        state_d = cnt_q == 3'(PIPE_DEPTH - 1) ? WRITE : DRAIN;
      end
      WRITE: if (!psum_full) begin
        state_d = last_win ? FINISH : COMPUTE;
        win_d   = last_win ? win_q : win_q + 1'b1;
        first_d = !last_win;
      end
      default: state_d = IDLE;
    endcase
  end
  // outputs decoded from state plus the handshake inputs
  always_comb begin
    pipe_en   = state_q == COMPUTE;
    acc_clear = state_q == COMPUTE && first_q;
    if_clear  = state_q == LOAD_WAIT && ready;
    psum_wr   = state_q == WRITE && !psum_full;
    done      = state_q == FINISH;
    ifmap_pop = state_q == FINISH;
    busy      = state_q != IDLE;
    cfg_err   = state_q == IDLE && start && !cfg_ok;
    win_idx   = win_q;
  end
`ifdef PE_SCHED_PERF_EN
  logic [15:0] perf_busy_q, perf_stall_q;
  // saturating perf counters, cleared when a pass is accepted
  always_ff @(posedge clk) begin
    if (rstn || (state_q == IDLE && start && cfg_ok)) begin
      perf_busy_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_busy_q  <= busy && !(&perf_busy_q) ? perf_busy_q + 16'd1 : perf_busy_q;
      perf_stall_q <= state_q == WRITE && psum_full && !(&perf_stall_q) ? perf_stall_q + 16'd1 : perf_stall_q;
    end
  end
  assign perf_busy_cycles  = perf_busy_q;
  assign perf_stall_cycles = perf_stall_q;
`endif
endmodule

// File: tb/tb_pe_sched_ctrl.sv
// tb_pe_sched_ctrl: directed self-checking bench for pe_sched_ctrl
module tb_pe_sched_ctrl;
  logic clk = 0, rstn = 1, start = 0, filter_ready = 1, ifmap_valid = 1, psum_full = 0;
  logic [4:0] filter_size = 0, ifmap_size = 0;
  logic offset_co, pipe_en, if_clear, acc_clear, psum_wr, ifmap_pop, busy, done, cfg_err;
  logic [4:0] win_idx;
`ifdef PE_SCHED_PERF_EN
  logic [15:0] perf_busy_cycles, perf_stall_cycles;
`endif
  int n_chk = 0, n_fail = 0, cyc = 0, fsz = 1, tap_q = 0, last_done = 0;
  pe_sched_ctrl #(.CONFIG_BIT(5), .PIPE_DEPTH(2), .WIN_CNT_WIDTH(5)) dut (
    .clk(clk), .rstn(rstn), .start(start), .filter_size(filter_size), .ifmap_size(ifmap_size),
    .filter_ready(filter_ready), .ifmap_valid(ifmap_valid), .offset_co(offset_co), .psum_full(psum_full),
    .pipe_en(pipe_en), .if_clear(if_clear), .acc_clear(acc_clear), .psum_wr(psum_wr), .ifmap_pop(ifmap_pop),
    .busy(busy), .done(done), .cfg_err(cfg_err),
`ifdef PE_SCHED_PERF_EN
    .perf_busy_cycles(perf_busy_cycles), .perf_stall_cycles(perf_stall_cycles),
`endif
    .win_idx(win_idx));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign offset_co = pipe_en && (acc_clear ? fsz == 1 : tap_q == fsz - 1);
  always @(posedge clk) tap_q <= (rstn || offset_co || !pipe_en) ? 0 : (acc_clear ? 1 : tap_q + 1);
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic run(input int f, input int s, input int sw, input int sn, input int lw, input bit restart);
    int k, rel, e, nw, ifc, acc, pe, done_rel, exp_t;
    nw = s - f + 1; e = lw + f + 4 + sw * (f + 3);
    k = 0; ifc = 0; acc = 0; pe = 0; done_rel = -1; exp_t = -10; rel = 0;
    fsz = f;
    @(posedge clk); #1;
    filter_size = 5'(f); ifmap_size = 5'(s);
    while (rel < 400 && done_rel < 0) begin
      ifmap_valid = rel > lw;
      psum_full = rel >= e && rel < e + sn;
      start = rel == 0 || (restart && rel == lw + 3);
      if (rel > 0) {filter_size, ifmap_size} = (restart && rel == lw + 3) ? {5'd1, 5'd1} : {5'd31, 5'd2};
      @(negedge clk);
      if (psum_full) chk("stall_pipe_en", pipe_en, 0);
      if (if_clear) begin ifc++; chk("if_clear_t", rel, lw + 1); end
      acc += acc_clear; pe += pipe_en;
      if (acc_clear) chk("acc_pipe_en", pipe_en, 1);
      if (psum_wr) begin
        exp_t = lw + f + 4 + k * (f + 3) + (k >= sw ? sn : 0);
        chk("wr_t", rel, exp_t);
        chk("win_idx", win_idx, k);
        k++;
      end
      if (done) begin
        done_rel = rel;
        chk("done_t", rel, exp_t + 1);
        chk("ifmap_pop", ifmap_pop, 1);
      end
      @(posedge clk); #1;
      rel++;
    end
    start = 0; psum_full = 0; ifmap_valid = 1;
    chk("n_writes", k, nw);
    chk("n_if_clear", ifc, 1);
    chk("n_acc_clear", acc, nw);
    chk("n_pipe_en", pe, nw * f);
    chk("done_seen", done_rel >= 0, 1);
    last_done = done_rel;
    @(negedge clk);
    chk("idle_busy", busy, 0);
  endtask
  task automatic bad(input int f, input int s);
    @(posedge clk); #1;
    start = 1; filter_size = 5'(f); ifmap_size = 5'(s);
    @(negedge clk);
    chk("cfg_err", cfg_err, 1);
    chk("cfg_busy", busy, 0);
    @(posedge clk); #1;
    start = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("cfg_after", {busy, pipe_en, cfg_err}, 0);
    end
  endtask
  task automatic reset_mid_drain();
    int bad_cnt;
    fsz = 3; bad_cnt = 0;
    @(posedge clk); #1;
    start = 1; filter_size = 3; ifmap_size = 5;
    @(posedge clk); #1;
    start = 0;
    repeat (5) @(posedge clk);
    #1 rstn = 1;
    @(posedge clk); #1;
    rstn = 0;
    @(negedge clk);
    chk("rst_outs", {pipe_en, if_clear, acc_clear, psum_wr, ifmap_pop, busy, done, cfg_err}, 0);
    chk("rst_win", win_idx, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bad_cnt += done + psum_wr + busy;
    end
    chk("rst_no_done", bad_cnt, 0);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", {pipe_en, if_clear, acc_clear, psum_wr, ifmap_pop, busy, done, cfg_err}, 0);
    chk("reset_win", win_idx, 0);
    @(posedge clk); #1;
    rstn = 0;
    run(3, 5, 99, 0, 0, 0);
    chk("base_total", last_done, 20);
    run(3, 5, 1, 4, 0, 0);
`ifdef PE_SCHED_PERF_EN
    chk("perf_stall", perf_stall_cycles, 4);
    chk("perf_busy", perf_busy_cycles, 24);
`endif
    bad(6, 4);
    bad(0, 3);
    run(1, 3, 99, 0, 0, 0);
    run(3, 5, 99, 0, 5, 0);
    run(3, 5, 99, 0, 0, 1);
    reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pe_sched_ctrl.md
Name: pe_sched_ctrl

Overview:
Top-level sequencer for one Eyeriss-style PE row pass.
- Latches the filter/ifmap configuration on `start` and waits until both scratchpads are loaded.
- Drives `pipe_en` and `if_clear` into the PE address generator, and marks the first tap of each window with `acc_clear`.
- After each window, drains the MAC pipeline and writes one psum into the output buffer, honouring output-buffer backpressure.
- Sits between the PE-array controller (start/done) and the PE address-generator/MAC datapath.

Parameters:
CONFIG_BIT, 5, width of the filter_size / ifmap_size config fields
PIPE_DEPTH, 2, MAC pipeline latency in cycles from last pipe_en to psum valid (range 1..7)
WIN_CNT_WIDTH, 5, width of the window counter (must be >= CONFIG_BIT)

Ports:
clk  input  1  clock, rising edge
rstn  input  1  synchronous, active-high reset
start  input  1  one-cycle request to begin a row pass; ignored unless in IDLE
filter_size  input  CONFIG_BIT  taps per window, sampled on accepted start
ifmap_size  input  CONFIG_BIT  ifmap row length, sampled on accepted start
filter_ready  input  1  filter spad holds a complete filter
ifmap_valid  input  1  ifmap spad holds a complete row
offset_co  input  1  address generator: current tap is the last tap of the window
psum_full  input  1  output psum buffer cannot accept a write
pipe_en  output  1  advance address generator / MAC issue
if_clear  output  1  zero the address-generator counters
acc_clear  output  1  MAC accumulator loads instead of accumulating this tap
psum_wr  output  1  write accumulator result to output buffer
ifmap_pop  output  1  release ifmap spad row (one-cycle pulse)
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse at end of pass
cfg_err  output  1  one-cycle pulse when start carries an illegal config
win_idx  output  WIN_CNT_WIDTH  index of the current window, 0-based

Behaviour:
Reset:
- All outputs 0, state IDLE, win_idx 0, latched config 0.
- Reset asserted in any state returns to IDLE on the next edge. No psum_wr or done is emitted for an aborted pass.

States: IDLE, LOAD_WAIT, COMPUTE, DRAIN, WRITE, FINISH.

IDLE:
- On start with filter_size >= 1 and ifmap_size >= filter_size: latch config, go to LOAD_WAIT.
- On start with an illegal config: cfg_err = 1 for one cycle, stay in IDLE.

LOAD_WAIT:
- When filter_ready && ifmap_valid: if_clear = 1 for that single cycle, win_idx <= 0, go to COMPUTE.

COMPUTE:
- pipe_en = 1 every cycle.
- acc_clear = 1 on the first cycle after entry (tap 0), 0 otherwise.
- On a cycle with pipe_en && offset_co: go to DRAIN.

DRAIN:
- pipe_en = 0 for exactly PIPE_DEPTH cycles (internal 3-bit counter), then go to WRITE.

WRITE:
- If psum_full: hold; psum_wr = 0.
- Else psum_wr = 1 for one cycle.
  - If win_idx == ifmap_size - filter_size (last window): go to FINISH.
  - Otherwise: win_idx <= win_idx + 1, go to COMPUTE.

FINISH:
- done = 1 and ifmap_pop = 1 for one cycle, then go to IDLE.

Timing and arithmetic:
- Window count = ifmap_size - filter_size + 1. Computed in CONFIG_BIT+1 bits; no wrap.
- Per-window cycles without stall = filter_size + PIPE_DEPTH + 1.
- filter_size == 1: COMPUTE lasts one cycle with acc_clear and pipe_en both high.
- start while busy: ignored, latched config unchanged.
- Config inputs may change after the start cycle without effect.
- psum_full is checked only in WRITE and never gates pipe_en.

Optional Feature:
Macro PE_SCHED_PERF_EN.
- Defined: adds outputs perf_busy_cycles [15:0] and perf_stall_cycles [15:0].
  - perf_busy_cycles counts cycles with busy = 1.
  - perf_stall_cycles counts WRITE cycles with psum_full = 1.
  - Both saturate at 0xFFFF and clear on accepted start or on reset.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- filter_size=3, ifmap_size=5, PIPE_DEPTH=2, ready inputs high, psum_full=0, start pulse:
  - 3 psum_wr pulses, 6 cycles apart; win_idx 0,1,2.
  - done one cycle after the third write; total 1+18+1 cycles from start to done.
- Same config with psum_full held high for 4 cycles at the second WRITE:
  - psum_wr delayed exactly 4 cycles; pipe_en stays 0 during the stall.
  - With PE_SCHED_PERF_EN: perf_stall_cycles = 4.
- start with filter_size=6, ifmap_size=4 -> cfg_err pulse, busy stays 0, no pipe_en.
- start with filter_size=0 -> cfg_err pulse, busy stays 0.
- filter_size=1, ifmap_size=3 -> every COMPUTE cycle has acc_clear=1 and pipe_en=1; 3 writes, 4 cycles apart.
- Edge cases:
  - ifmap_valid low for 5 cycles after start: stay in LOAD_WAIT, if_clear fires only on the cycle inputs go high.
  - rstn asserted mid-DRAIN: next cycle all outputs 0, no done.
  - Second start pulse during COMPUTE: ignored.
